sync_ram_arbiter: RTL and testbench
===================================

# sync_ram_arbiter

Two-requester round-robin front-end for the single-port `sync_ram`. It clears the RAM after reset, then grants at most one access per cycle to one of two requesters and returns read data one cycle after the grant. It sits between the two client blocks and the RAM instance, and drives all RAM write, address and data ports.

## Interface
- `DATA_WIDTH`, 4, word width; must match the RAM.
- `DEPTH`, 4, number of RAM words.
- `ADDR_WIDTH`, 2, address width; `2**ADDR_WIDTH >= DEPTH`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester grant; handshake completes when valid & ready.
- `req_we`  in  2  1 = write, 0 = read.
- `req_addr`  in  2*ADDR_WIDTH  packed; requester i uses slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  2*DATA_WIDTH  packed write data, same slicing.
- `rsp_valid`  out  2  one-cycle read-response pulse per requester.
- `rsp_rdata`  out  DATA_WIDTH  shared read-data bus, qualified by `rsp_valid`.
- `init_done`  out  1  high once the clear sweep has finished.
- `ram_wr_en`  out  1  to RAM `wr_en`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr_i`.
- `ram_wr_data`  out  DATA_WIDTH  to RAM `wr_data`.
- `ram_rd_data`  in  DATA_WIDTH  from RAM `rd_data`; valid the cycle after the address is presented.

## Operation
- The FSM has two states, ST_INIT and ST_RUN. Reset forces ST_INIT with the init counter at 0.
- **ST_INIT:**
  - Drives `ram_wr_en=1`, `ram_addr=cnt`, `ram_wr_data=0`. `cnt` increments every cycle.
  - After the write to `DEPTH-1`, the FSM moves to ST_RUN and `init_done` goes to 1.
  - `req_ready=0` throughout.
- **ST_RUN, grant logic** (combinational from `req_valid` and the `ptr` register):
  - Only one requester valid: that requester is granted.
  - Both valid: requester `ptr` is granted.
  - Neither valid: no grant.
  - After any grant to requester i, `ptr <= ~i`. `ptr` resets to 0.
- **Handshake:**
  - `req_ready[i]` is high only while requester i is granted.
  - A requester holds `valid`, `we`, `addr` and `wdata` stable until it sees ready.
  - At most one bit of `req_ready` is high in any cycle.
- **RAM drive:**
  - Granted write: `ram_wr_en=1`, with the granted address and data.
  - Granted read: `ram_wr_en=0`, with the granted address.
  - No grant: `ram_wr_en=0`, `ram_addr=0`, `ram_wr_data=0`.
- **Read responses:**
  - A read granted in cycle N sets the registered tag (`rsp_pend`, `rsp_id`).
  - In cycle N+1, `rsp_valid[rsp_id]=1` and `rsp_rdata=ram_rd_data`.
  - Responses have no backpressure.
  - `rsp_rdata=0` whenever no `rsp_valid` bit is high.
  - Writes produce no response.
- **Out-of-range address** (`addr >= DEPTH`): the handshake still completes.
  - Write: suppressed (`ram_wr_en=0`).
  - Read: returns `rsp_valid` with `rsp_rdata=0`.
- **Reset mid-operation:** the cycle after `rst` is sampled, every output is at its reset value. Any pending response is dropped, not delivered. The init sweep restarts from address 0.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `init_done=0`, `ram_wr_en=0`, `ram_addr=0`, `ram_wr_data=0`.
- Init sweep takes exactly DEPTH cycles after `rst` falls. `init_done=1` from cycle DEPTH onward (the first cycle after rst falls is cycle 0).
- Accepted throughput is one access per cycle in total, in ST_RUN.
- Read latency is 1 cycle from handshake to `rsp_valid`.
- A write in cycle N followed by a read of the same address in N+1 returns the new data in N+2.
- Back-to-back reads in N and N+1 give responses in N+1 and N+2, with no gap.
- `req_ready`, `ram_wr_en`, `ram_addr` and `ram_wr_data` are combinational from registered state and inputs. Requesters must not make `req_valid` depend on `req_ready`.

## Structure
- Package `sync_ram_pkg` holds:
  - FSM state encoding: ST_INIT, ST_RUN.
  - `NUM_REQ=2`.
- Sub-module `ram_rr_arbiter` holds the `ptr` register, grant decode and one-hot `req_ready`.
- The top level holds the FSM, init counter, RAM muxing, range check and response tag register.

## Test plan
1. **Reset and init sweep.** Hold `rst` for 3 cycles, then release.
   - Required: `ram_wr_en=1` with addr 0,1,2,3 and data 0 over 4 cycles.
   - `init_done=1` in the 5th cycle; `req_ready=0` throughout the sweep.
2. **Write then read, one requester.** Requester 0 writes addr 2 with 4'b0110, then reads addr 2.
   - Required: `rsp_valid=2'b01` one cycle after the read handshake, `rsp_rdata=4'b0110`.
3. **Contention.** Preload addr1=4'b0101 and addr3=4'b0111. Hold both requesters valid on reads (req0→1, req1→3) for 4 cycles.
   - Required: grants 0,1,0,1.
   - Responses alternate 4'b0101 and 4'b0111 with no idle cycle.
4. **Unwritten address after init.** Read addr 0.
   - Required: `rsp_rdata=4'b0000`.
5. **Reset mid-read.** Assert `rst` in the cycle after a read handshake.
   - Required: that response never appears.
   - `init_done` drops, and the sweep restarts at addr 0.
6. **Out of range.** With DEPTH=3 and ADDR_WIDTH=2, write addr 3, then read addr 3.
   - Required: `ram_wr_en` stays 0 for the write.
   - The read returns `rsp_valid` with `rsp_rdata=0`.

Source files
------------

// File: rtl/sync_ram_pkg.sv
// Shared types for the sync_ram front-end: FSM encoding and requester count.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sync_ram_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sync_ram_arbiter_if.sv
// Requester-side bundle: request handshake plus shared read-response bus.
// Latency: n/a (wires only).
// Backpressure: req_ready per requester; responses have none.
interface sync_ram_arbiter_if import sync_ram_pkg::*; #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  // requester side
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-way round-robin grant: lone requester wins, contention goes to ptr.
// Latency: combinational grant; ptr updates on the granting edge.
// Backpressure: req_ready is the one-hot grant, low whenever en is low.
module ram_rr_arbiter import sync_ram_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               gnt_vld,
  output logic               gnt_id
);

  logic ptr;

  // ptr names the requester favoured on the next contended cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt_vld) begin
      ptr <= ~gnt_id;
    end
  end

  // grant decode: only one valid wins outright, both valid defers to ptr
  always_comb begin
    gnt_vld   = en && (req_valid != '0);
    gnt_id    = (&req_valid) ? ptr : req_valid[1];
    req_ready = '0;
    if (gnt_vld) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/sync_ram_arbiter.sv
// Front-end for a single-port sync RAM: clear sweep after reset, then RR access.
// Latency: RAM drive combinational; read data returned one cycle after grant.
// Backpressure: per-requester req_ready; responses cannot be stalled.
module sync_ram_arbiter import sync_ram_pkg::*; #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_ram_arbiter_if.slave     bus,
  output logic                  init_done,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic                    arb_en;
  logic                    gnt_vld;
  logic                    gnt_id;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    in_range;
  logic                    rsp_pend;
  logic                    rsp_id;
  logic                    rsp_oor;

  ram_rr_arbiter u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req_valid (bus.req_valid),
    .req_ready (bus.req_ready),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id)
  );

  // fields of whichever requester currently holds the grant
  always_comb begin
    sel_we    = gnt_id ? bus.req_we[1] : bus.req_we[0];
    sel_addr  = gnt_id ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_addr[ADDR_WIDTH-1:0];
    sel_wdata = gnt_id ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_wdata[DATA_WIDTH-1:0];
    in_range  = ({1'b0, sel_addr} < DEPTH_W);
  end

  // FSM and sweep counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state and RAM drive; everything idles while rst is high
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    arb_en      = 1'b0;
    init_done   = 1'b0;
    ram_wr_en   = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          ram_wr_en = 1'b1;
          ram_addr  = cnt;
          cnt_nxt   = cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_ADDR) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
        ST_RUN: begin
          init_done = 1'b1;
          arb_en    = 1'b1;
          if (gnt_vld) begin
            // out-of-range writes still handshake but never reach the RAM
            ram_addr = sel_addr;
            if (sel_we) begin
              ram_wr_en   = in_range;
              ram_wr_data = sel_wdata;
            end
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  // read tag: remembers who to answer next cycle and whether to force zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_oor  <= 1'b0;
    end else begin
      rsp_pend <= gnt_vld && !sel_we;
      rsp_id   <= gnt_id;
      rsp_oor  <= !in_range;
    end
  end

  // response pulse; a reset arriving with a pending tag drops the response
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (rsp_pend && !rst) begin
      bus.rsp_valid[rsp_id] = 1'b1;
      if (!rsp_oor) begin
        bus.rsp_rdata = ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Bench for sync_ram_arbiter: table vectors, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, rst3;
  int   tests = 0;
  int   fails = 0;

  sync_ram_arbiter_if #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) bus4();
  sync_ram_arbiter_if #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) bus3();

  logic       init_done4, wen4, init_done3, wen3;
  logic [1:0] addr4, addr3;
  logic [3:0] wd4, rd4, wd3, rd3;

  sync_ram_arbiter #(.DATA_WIDTH(4), .DEPTH(4), .ADDR_WIDTH(2)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4), .init_done(init_done4),
    .ram_wr_en(wen4), .ram_addr(addr4), .ram_wr_data(wd4), .ram_rd_data(rd4)
  );

  sync_ram_arbiter #(.DATA_WIDTH(4), .DEPTH(3), .ADDR_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3), .init_done(init_done3),
    .ram_wr_en(wen3), .ram_addr(addr3), .ram_wr_data(wd3), .ram_rd_data(rd3)
  );

  // RAM models; nonzero power-up contents so the clear sweep is observable
  logic [3:0] mem4 [4] = '{4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0] mem3 [4] = '{4'hF, 4'hF, 4'hF, 4'hA};

  always @(posedge clk) begin
    if (wen4) mem4[addr4] <= wd4;
    rd4 <= mem4[addr4];
    if (wen3) mem3[addr3] <= wd3;
    rd3 <= mem3[addr3];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // release reset on dut4 and watch the clear sweep with both requesters asking
  task automatic sweep4();
    bus4.req_valid = 2'b11;
    bus4.req_we    = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("sweep_wen", wen4, 1);
        chk("sweep_addr", addr4, k);
        chk("sweep_wdata", wd4, 0);
        chk("sweep_ready", bus4.req_ready, 0);
        chk("sweep_init_done", init_done4, 0);
      end else begin
        chk("init_done_set", init_done4, 1);
        chk("idle_ready", bus4.req_ready, 0);
      end
      chk("sweep_rsp_valid", bus4.rsp_valid, 0);
      @(posedge clk); #1;
      if (k == 3) bus4.req_valid = 2'b00;
    end
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [1:0] we;
    logic [1:0] a0, a1;
    logic [3:0] d0, d1;
    logic [1:0] rdy;
    logic       wen;
    logic [1:0] addr;
    logic [1:0] rv;
    logic [3:0] rd;
  } vec_t;

  vec_t tbl [11];

  // random-phase reference model state
  logic [3:0] m [4];
  logic       p [2];
  logic       pwe [2];
  logic [1:0] pa [2];
  logic [3:0] pd [2];
  logic       pref;
  logic [1:0] exp_rv;
  logic [3:0] exp_rd;

  initial begin
    // write a2=6, read a2, preload a1=5 / a3=7, contend on reads, read unwritten a0
    tbl[0]  = '{2'b01, 2'b01, 2'd2, 2'd0, 4'h6, 4'h0, 2'b01, 1'b1, 2'd2, 2'b00, 4'h0};
    tbl[1]  = '{2'b01, 2'b00, 2'd2, 2'd0, 4'h0, 4'h0, 2'b01, 1'b0, 2'd2, 2'b00, 4'h0};
    tbl[2]  = '{2'b00, 2'b00, 2'd0, 2'd0, 4'h0, 4'h0, 2'b00, 1'b0, 2'd0, 2'b01, 4'h6};
    tbl[3]  = '{2'b01, 2'b01, 2'd1, 2'd0, 4'h5, 4'h0, 2'b01, 1'b1, 2'd1, 2'b00, 4'h0};
    tbl[4]  = '{2'b10, 2'b10, 2'd0, 2'd3, 4'h0, 4'h7, 2'b10, 1'b1, 2'd3, 2'b00, 4'h0};
    tbl[5]  = '{2'b11, 2'b00, 2'd1, 2'd3, 4'h0, 4'h0, 2'b01, 1'b0, 2'd1, 2'b00, 4'h0};
    tbl[6]  = '{2'b11, 2'b00, 2'd1, 2'd3, 4'h0, 4'h0, 2'b10, 1'b0, 2'd3, 2'b01, 4'h5};
    tbl[7]  = '{2'b11, 2'b00, 2'd1, 2'd3, 4'h0, 4'h0, 2'b01, 1'b0, 2'd1, 2'b10, 4'h7};
    tbl[8]  = '{2'b11, 2'b00, 2'd1, 2'd3, 4'h0, 4'h0, 2'b10, 1'b0, 2'd3, 2'b01, 4'h5};
    tbl[9]  = '{2'b01, 2'b00, 2'd0, 2'd0, 4'h0, 4'h0, 2'b01, 1'b0, 2'd0, 2'b10, 4'h7};
    tbl[10] = '{2'b00, 2'b00, 2'd0, 2'd0, 4'h0, 4'h0, 2'b00, 1'b0, 2'd0, 2'b01, 4'h0};

    rst4 = 1'b1;
    rst3 = 1'b1;
    bus4.req_valid = '0; bus4.req_we = '0; bus4.req_addr = '0; bus4.req_wdata = '0;
    bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0;

    // reset values held for three cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_ready", bus4.req_ready, 0);
      chk("rst_rsp_valid", bus4.rsp_valid, 0);
      chk("rst_rsp_rdata", bus4.rsp_rdata, 0);
      chk("rst_init_done", init_done4, 0);
      chk("rst_wen", wen4, 0);
      chk("rst_addr", addr4, 0);
      chk("rst_wdata", wd4, 0);
    end
    @(posedge clk); #1;
    rst4 = 1'b0;
    sweep4();

    // table vectors, one per cycle
    for (int i = 0; i < 11; i++) begin
      bus4.req_valid = tbl[i].valid;
      bus4.req_we    = tbl[i].we;
      bus4.req_addr  = {tbl[i].a1, tbl[i].a0};
      bus4.req_wdata = {tbl[i].d1, tbl[i].d0};
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), bus4.req_ready, tbl[i].rdy);
      chk($sformatf("v%0d_wen", i), wen4, tbl[i].wen);
      chk($sformatf("v%0d_addr", i), addr4, tbl[i].addr);
      chk($sformatf("v%0d_rsp_valid", i), bus4.rsp_valid, tbl[i].rv);
      chk($sformatf("v%0d_rsp_rdata", i), bus4.rsp_rdata, tbl[i].rd);
      @(posedge clk); #1;
    end

    // reset the cycle after a read handshake: the response must vanish
    bus4.req_valid = 2'b01;
    bus4.req_we    = 2'b00;
    bus4.req_addr  = {2'd0, 2'd1};
    @(negedge clk);
    chk("midrst_ready", bus4.req_ready, 2'b01);
    @(posedge clk); #1;
    rst4 = 1'b1;
    bus4.req_valid = 2'b00;
    @(negedge clk);
    chk("midrst_rsp_valid", bus4.rsp_valid, 0);
    chk("midrst_rsp_rdata", bus4.rsp_rdata, 0);
    chk("midrst_init_done", init_done4, 0);
    chk("midrst_wen", wen4, 0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    sweep4();

    // random traffic against the behavioural model
    for (int i = 0; i < 4; i++) m[i] = 4'h0;
    for (int i = 0; i < 2; i++) begin
      p[i] = 1'b0; pwe[i] = 1'b0; pa[i] = '0; pd[i] = '0;
    end
    pref   = 1'b0;
    exp_rv = 2'b00;
    exp_rd = 4'h0;
    for (int c = 0; c < 400; c++) begin
      logic       g_vld;
      logic       g;
      logic [1:0] exp_rdy;
      for (int i = 0; i < 2; i++) begin
        if (!p[i] && $urandom_range(0, 2) != 0) begin
          p[i]   = 1'b1;
          pwe[i] = 1'($urandom_range(0, 1));
          pa[i]  = 2'($urandom_range(0, 3));
          pd[i]  = 4'($urandom_range(0, 15));
        end
      end
      bus4.req_valid = {p[1], p[0]};
      bus4.req_we    = {pwe[1], pwe[0]};
      bus4.req_addr  = {pa[1], pa[0]};
      bus4.req_wdata = {pd[1], pd[0]};
      g_vld = p[0] || p[1];
      g     = (p[0] && p[1]) ? pref : p[1];
      exp_rdy = g_vld ? (g ? 2'b10 : 2'b01) : 2'b00;
      @(negedge clk);
      chk("rnd_ready", bus4.req_ready, exp_rdy);
      chk("rnd_rsp_valid", bus4.rsp_valid, exp_rv);
      chk("rnd_rsp_rdata", bus4.rsp_rdata, exp_rd);
      exp_rv = 2'b00;
      exp_rd = 4'h0;
      if (g_vld) begin
        if (pwe[g]) begin
          m[pa[g]] = pd[g];
        end else begin
          exp_rv = g ? 2'b10 : 2'b01;
          exp_rd = m[pa[g]];
        end
        p[g] = 1'b0;
        pref = ~g;
      end
      @(posedge clk); #1;
    end
    bus4.req_valid = 2'b00;

    // DEPTH=3 instance: short sweep, then out-of-range write and read of addr 3
    rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) begin
        chk("d3_sweep_wen", wen3, 1);
        chk("d3_sweep_addr", addr3, k);
      end else begin
        chk("d3_init_done", init_done3, 1);
      end
      @(posedge clk); #1;
    end
    bus3.req_valid = 2'b01;
    bus3.req_we    = 2'b01;
    bus3.req_addr  = {2'd0, 2'd3};
    bus3.req_wdata = {4'h0, 4'hF};
    @(negedge clk);
    chk("oor_wr_ready", bus3.req_ready, 2'b01);
    chk("oor_wr_wen", wen3, 0);
    @(posedge clk); #1;
    bus3.req_we = 2'b00;
    @(negedge clk);
    chk("oor_rd_ready", bus3.req_ready, 2'b01);
    chk("oor_rd_wen", wen3, 0);
    @(posedge clk); #1;
    bus3.req_valid = 2'b00;
    @(negedge clk);
    chk("oor_rsp_valid", bus3.rsp_valid, 2'b01);
    chk("oor_rsp_rdata", bus3.rsp_rdata, 0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
